t09_sound_sequencer: RTL and testbench

//  Schedules game sound effects onto the single 8-bit tone-divider bus that drives the

---
 rtl/t09_sound_sequencer.sv | 172 +++++++++++++++++
 tb/tb_t09_sound_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/t09_sound_sequencer.sv
// t09_sound_sequencer: edge-detected game sound events arbitrated onto
// one tone-divider bus as timed note sequences followed by a silent gap.
module t09_sound_sequencer #(
  parameter int TICKS_PER_MS = 10000,
  parameter int GOOD_MS      = 50,
  parameter int BAD_MS       = 200,
  parameter int MOVE_MS      = 20,
  parameter int GAP_MS       = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       goodColl_i,
  input  logic       badColl_i,
  input  logic [3:0] direction_i,
  input  logic       mute_i,
  output logic [7:0] freq_o,
  output logic       tone_en_o,
  output logic       busy_o
);

  localparam int M1 = (BAD_MS > GOOD_MS) ? BAD_MS : GOOD_MS;
  localparam int M2 = (M1 > MOVE_MS) ? M1 : MOVE_MS;
  localparam int MX = (M2 > GAP_MS) ? M2 : GAP_MS;
  localparam int CW = $clog2(MX * TICKS_PER_MS + 1);

  localparam logic [CW-1:0] GOOD_C = CW'(GOOD_MS * TICKS_PER_MS - 1);
  localparam logic [CW-1:0] BAD_C  = CW'(BAD_MS * TICKS_PER_MS - 1);
  localparam logic [CW-1:0] MOVE_C = CW'(MOVE_MS * TICKS_PER_MS - 1);
  localparam logic [CW-1:0] GAP_C  = CW'(GAP_MS * TICKS_PER_MS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_GAP
  } state_e;

  // Class value doubles as its bit index in the pending vector.
  typedef enum logic [1:0] {
    C_MOVE,
    C_GOOD,
    C_BAD
  } cls_e;

  function automatic logic [7:0] note_freq(cls_e c, logic n);
    case (c)
      C_BAD:   return n ? 8'd159 : 8'd126;
      C_GOOD:  return n ? 8'd67 : 8'd89;
      default: return 8'd149;
    endcase
  endfunction

  function automatic logic [CW-1:0] note_dur(cls_e c);
    case (c)
      C_BAD:   return BAD_C;
      C_GOOD:  return GOOD_C;
      default: return MOVE_C;
    endcase
  endfunction

  function automatic cls_e pick(logic [2:0] v);
    if (v[2]) return C_BAD;
    if (v[1]) return C_GOOD;
    return C_MOVE;
  endfunction

  state_e        state_q, state_d;
  cls_e          cls_q, cls_d;
  logic          note_q, note_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    freq_q, freq_d;
  logic [2:0]    pend_q, pend_d;
  logic          good_q, bad_q, dir_q;

  logic [2:0] req;
  logic [2:0] cand;
  logic       last;
  logic       start;
  cls_e       start_cls;

  always_comb begin
    req = {badColl_i & ~bad_q,
           goodColl_i & ~good_q,
           (|direction_i) & ~dir_q};
    cand = pend_q | req;
    last = (cls_q == C_MOVE) | note_q;
    state_d = state_q;
    cls_d = cls_q;
    note_d = note_q;
    cnt_d = cnt_q;
    freq_d = freq_q;
    pend_d = cand;
    start = 1'b0;
    start_cls = pick(cand);
    if (mute_i) begin
      state_d = S_IDLE;
      pend_d = '0;
      cnt_d = '0;
      freq_d = '0;
      note_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (|cand) start = 1'b1;
        end
        S_PLAY: begin
          if (req[2] && cls_q != C_BAD) begin
            start = 1'b1;
            start_cls = C_BAD;
          end else if (cnt_q == '0) begin
            if (last) begin
              state_d = S_GAP;
              cnt_d = GAP_C;
              freq_d = '0;
            end else begin
              note_d = 1'b1;
              cnt_d = note_dur(cls_q);
              freq_d = note_freq(cls_q, 1'b1);
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            if (|cand) start = 1'b1;
            else state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (start) begin
        state_d = S_PLAY;
        cls_d = start_cls;
        note_d = 1'b0;
        cnt_d = note_dur(start_cls);
        freq_d = note_freq(start_cls, 1'b0);
        pend_d = cand & ~(3'b001 << start_cls);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cls_q <= C_MOVE;
      note_q <= 1'b0;
      cnt_q <= '0;
      freq_q <= '0;
      pend_q <= '0;
      good_q <= 1'b0;
      bad_q <= 1'b0;
      dir_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q <= cls_d;
      note_q <= note_d;
      cnt_q <= cnt_d;
      freq_q <= freq_d;
      pend_q <= pend_d;
      good_q <= goodColl_i;
      bad_q <= badColl_i;
      dir_q <= |direction_i;
    end
  end

  assign tone_en_o = (state_q == S_PLAY);
  assign busy_o = (state_q != S_IDLE);
  assign freq_o = tone_en_o ? freq_q : 8'd0;

endmodule

// File: tb/tb_t09_sound_sequencer.sv
// tb_t09_sound_sequencer: scenario and random stimulus checked each cycle
// against a playlist model (one queued frequency per remaining cycle).
module tb_t09_sound_sequencer;

  localparam int TPM = 4;
  localparam int GOOD_MS = 2;
  localparam int BAD_MS = 3;
  localparam int MOVE_MS = 1;
  localparam int GAP_MS = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       goodColl;
  logic       badColl;
  logic [3:0] dir;
  logic       mute;
  logic [7:0] freq;
  logic       tone_en;
  logic       busy;

  always #5 clk = ~clk;

  t09_sound_sequencer #(
    .TICKS_PER_MS(TPM),
    .GOOD_MS(GOOD_MS),
    .BAD_MS(BAD_MS),
    .MOVE_MS(MOVE_MS),
    .GAP_MS(GAP_MS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .goodColl_i(goodColl),
    .badColl_i(badColl),
    .direction_i(dir),
    .mute_i(mute),
    .freq_o(freq),
    .tone_en_o(tone_en),
    .busy_o(busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  int     mq[$];
  int     m_cls;
  bit [2:0] m_pend;
  bit     m_gq, m_bq, m_dq;

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Class ids: 2 = bad, 1 = good, 0 = move.
  function automatic void m_start(int c);
    int f0, f1, nn, d;
    case (c)
      2: begin f0 = 126; f1 = 159; nn = 2; d = BAD_MS * TPM; end
      1: begin f0 = 89; f1 = 67; nn = 2; d = GOOD_MS * TPM; end
      default: begin f0 = 149; f1 = 0; nn = 1; d = MOVE_MS * TPM; end
    endcase
    mq.delete();
    m_cls = c;
    for (int i = 0; i < nn; i++)
      for (int k = 0; k < d; k++)
        mq.push_back(i == 0 ? f0 : f1);
    for (int k = 0; k < GAP_MS * TPM; k++)
      mq.push_back(0);
  endfunction

  function automatic void model_step();
    bit rb, rg, rm;
    bit [2:0] req, cand;
    int w;
    if (rst) begin
      mq.delete();
      m_pend = '0;
      m_gq = 0;
      m_bq = 0;
      m_dq = 0;
      return;
    end
    rb = badColl & !m_bq;
    rg = goodColl & !m_gq;
    rm = (|dir) & !m_dq;
    m_bq = badColl;
    m_gq = goodColl;
    m_dq = |dir;
    if (mute) begin
      mq.delete();
      m_pend = '0;
      return;
    end
    req = {rb, rg, rm};
    cand = m_pend | req;
    if (mq.size() != 0 && mq[0] != 0 && rb && m_cls != 2) begin
      m_start(2);
      m_pend = cand & 3'b011;
      return;
    end
    if (mq.size() != 0) void'(mq.pop_front());
    if (mq.size() == 0 && cand != 0) begin
      w = cand[2] ? 2 : (cand[1] ? 1 : 0);
      m_start(w);
      m_pend = cand & ~(3'b001 << w);
    end else begin
      m_pend = cand;
    end
  endfunction

  task automatic cyc();
    int ef;
    model_step();
    @(posedge clk);
    @(negedge clk);
    ef = (mq.size() != 0) ? mq[0] : 0;
    chk("freq", int'(freq), ef);
    chk("tone_en", int'(tone_en), int'(ef != 0));
    chk("busy", int'(busy), int'(mq.size() != 0));
  endtask

  initial begin
    int n149;
    rst = 1'b1;
    goodColl = 1'b0;
    badColl = 1'b0;
    dir = 4'b0;
    mute = 1'b0;
    m_cls = 0;
    m_pend = '0;
    m_gq = 0;
    m_bq = 0;
    m_dq = 0;
    cyc();
    cyc();
    chk("rst_freq", int'(freq), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    cyc();

    goodColl = 1'b1;
    cyc();
    chk("t1_first", int'(freq), 89);
    goodColl = 1'b0;
    repeat (7) cyc();
    chk("t1_last89", int'(freq), 89);
    cyc();
    chk("t1_67", int'(freq), 67);
    repeat (8) cyc();
    chk("t1_gap", int'(tone_en), 0);
    chk("t1_gapbusy", int'(busy), 1);
    repeat (4) cyc();
    chk("t1_idle", int'(busy), 0);

    dir = 4'b0010;
    n149 = 0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (freq == 8'd149) n149++;
    end
    chk("t2_count149", n149, 4);
    dir = 4'b0;
    cyc();

    goodColl = 1'b1;
    dir = 4'b0100;
    cyc();
    chk("t3_good", int'(freq), 89);
    goodColl = 1'b0;
    dir = 4'b0;
    repeat (20) cyc();
    chk("t3_move", int'(freq), 149);
    repeat (10) cyc();

    dir = 4'b0001;
    cyc();
    dir = 4'b0;
    cyc();
    badColl = 1'b1;
    cyc();
    chk("t4_preempt", int'(freq), 126);
    badColl = 1'b0;
    repeat (40) cyc();
    chk("t4_noreplay", int'(busy), 0);

    badColl = 1'b1;
    cyc();
    badColl = 1'b0;
    repeat (5) cyc();
    mute = 1'b1;
    cyc();
    chk("t5_freq", int'(freq), 0);
    chk("t5_busy", int'(busy), 0);
    mute = 1'b0;
    repeat (10) cyc();
    chk("t5_idle", int'(busy), 0);

    goodColl = 1'b1;
    cyc();
    goodColl = 1'b0;
    repeat (10) cyc();
    chk("t6_note2", int'(freq), 67);
    rst = 1'b1;
    cyc();
    chk("t6_rst", int'(busy), 0);
    rst = 1'b0;
    goodColl = 1'b1;
    cyc();
    chk("t6_replay", int'(freq), 89);
    goodColl = 1'b0;
    repeat (30) cyc();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) goodColl = ~goodColl;
      if ($urandom_range(0, 29) == 0) badColl = ~badColl;
      if ($urandom_range(0, 19) == 0) dir = 4'($urandom);
      if (mute) mute = ($urandom_range(0, 3) != 0);
      else mute = ($urandom_range(0, 249) == 0);
      rst = ($urandom_range(0, 599) == 0);
      cyc();
    end
    rst = 1'b0;
    mute = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
